// File: rtl/jstk_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jstk_move_ctrl
//  Function : Turns the joystick direction bus into debounced one-shot move
//             commands. Optional auto-repeat while a direction is held is
//             enabled by defining MOVE_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module jstk_move_ctrl #(
   parameter int SAMPLE_DIV     = 4096,
   parameter int STABLE_SAMPLES = 3,
   parameter int REPEAT_SAMPLES = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] dir,
   input  logic       enable,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic       busy,
   output logic [7:0] move_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUAL    = 2'd1,
      ISSUE   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int DW = $clog2(SAMPLE_DIV);
   localparam int SW = $clog2(STABLE_SAMPLES + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_SAMPLES - 1);

   state_t        state;
   logic [DW-1:0] div;
   logic [SW-1:0] stab;
   logic [SW-1:0] rel;
   logic [1:0]    cand;
   logic          tick;
   logic          centre;
   logic [1:0]    d;

`ifdef MOVE_REPEAT_EN
   localparam int RW = $clog2(REPEAT_SAMPLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SAMPLES - 1);
   logic [RW-1:0] rep;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = (REPEAT_SAMPLES > 0);
`endif

   assign tick = (div == DIV_LAST);
   assign busy = (state != IDLE);

   // Codes 5..7 are not legal directions and are folded into centre.
   always_comb begin
      centre = 1'b1;
      d      = 2'b00;
      if (dir >= 3'd1 && dir <= 3'd4) begin
         centre = 1'b0;
         d      = 2'(dir - 3'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div        <= '0;
         stab       <= '0;
         rel        <= '0;
         cand       <= 2'b00;
         move_valid <= 1'b0;
         move_dir   <= 2'b00;
         move_count <= 8'd0;
`ifdef MOVE_REPEAT_EN
         rep        <= '0;
`endif
      end else begin
         div <= tick ? '0 : div + 1'b1;
         case (state)
            IDLE: begin
               if (tick && enable && !centre) begin
                  cand <= d;
                  stab <= SW'(1);
                  if (STABLE_SAMPLES == 1) begin
                     state      <= ISSUE;
                     move_valid <= 1'b1;
                     move_dir   <= d;
                  end else begin
                     state <= QUAL;
                  end
               end
            end
            QUAL: begin
               if (tick) begin
                  if (!enable || centre) begin
                     state <= IDLE;
                  end else if (d != cand) begin
                     cand <= d;
                     stab <= SW'(1);
                  end else if (stab == STAB_LAST) begin
                     state      <= ISSUE;
                     move_valid <= 1'b1;
                     move_dir   <= cand;
                  end else begin
                     stab <= stab + 1'b1;
                  end
               end
            end
            // Ticks are ignored here so a coincident tick never reaches RELEASE.
            ISSUE: begin
               if (move_valid && move_ready) begin
                  move_valid <= 1'b0;
                  move_count <= move_count + 8'd1;
                  rel        <= '0;
`ifdef MOVE_REPEAT_EN
                  rep        <= '0;
`endif
                  state      <= RELEASE;
               end
            end
            RELEASE: begin
               if (tick) begin
                  if (centre) begin
                     if (rel == STAB_LAST) begin
                        rel   <= '0;
                        state <= IDLE;
                     end else begin
                        rel <= rel + 1'b1;
                     end
                  end else begin
                     rel <= '0;
                  end
`ifdef MOVE_REPEAT_EN
                  if (!centre && d == cand) begin
                     if (rep == REP_LAST) begin
                        rep <= '0;
                        if (enable) begin
                           state      <= ISSUE;
                           move_valid <= 1'b1;
                           move_dir   <= cand;
                        end
                     end else begin
                        rep <= rep + 1'b1;
                     end
                  end else begin
                     rep <= '0;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jstk_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jstk_move_ctrl
//  Function : Directed-vector bench for jstk_move_ctrl (SAMPLE_DIV=4,
//             STABLE_SAMPLES=3, REPEAT_SAMPLES=5); MOVE_REPEAT_EN aware.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jstk_move_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dir;
   logic       enable;
   logic       move_ready;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       busy;
   logic [7:0] move_count;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int t       = 0;
   int exp_cnt = 0;

   jstk_move_ctrl #(
      .SAMPLE_DIV    (4),
      .STABLE_SAMPLES(3),
      .REPEAT_SAMPLES(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dir       (dir),
      .enable    (enable),
      .move_ready(move_ready),
      .move_valid(move_valid),
      .move_dir  (move_dir),
      .busy      (busy),
      .move_count(move_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then sample point on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // which: 0 waits for move_valid=1, 1 waits for busy=0.
   task automatic wait_sig(input int which, input int bound, input string tag);
      int n;
      bit met;
      n = 0;
      met = 0;
      while (n < bound) begin
         if ((which == 0 && move_valid === 1'b1) || (which == 1 && busy === 1'b0)) begin
            met = 1;
            break;
         end
         step();
         n++;
      end
      if (!met) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; dir = 3'd0; enable = 1'b1; move_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", move_valid, 0);
      chk("rst_dir",   move_dir,   0);
      chk("rst_busy",  busy,       0);
      chk("rst_count", move_count, 0);

      // Up held: ticks at 4, 8, 12 -> valid at 12, handshake at 13.
      rst = 1'b0; dir = 3'd1; cyc = 0;
      run_to(3);   chk("idle_before_tick", busy, 0);
      run_to(11);  chk("qual_no_valid", move_valid, 0);
      chk("qual_busy", busy, 1);
      run_to(12);  chk("up_valid", move_valid, 1);
      chk("up_dir", move_dir, 2'b00);
      run_to(13);  chk("up_hs_valid", move_valid, 0);
      chk("up_count", move_count, 1);
      chk("release_busy", busy, 1);
      dir = 3'd0;
      run_to(23);  chk("release_pending", busy, 1);
      run_to(24);  chk("release_idle", busy, 0);

      // Right with ready low: held stable, dir change ignored while pending.
      dir = 3'd4; move_ready = 1'b0;
      run_to(36);  chk("right_valid", move_valid, 1);
      chk("right_dir", move_dir, 2'b11);
      while (cyc < 56) begin
         if (cyc == 40) dir = 3'd0;
         step();
         chk("right_hold_valid", move_valid, 1);
         chk("right_hold_dir", move_dir, 2'b11);
      end
      chk("right_hold_count", move_count, 1);
      move_ready = 1'b1;
      run_to(57);  chk("right_hs_valid", move_valid, 0);
      chk("right_count", move_count, 2);
      run_to(68);  chk("right_release_idle", busy, 0);

      // Ticks 72,76 left; 80,84,88 down -> candidate restarts, down issued.
      dir = 3'd3;
      run_to(76);  dir = 3'd2;
      run_to(80);  chk("restart_no_issue", move_valid, 0);
      run_to(87);  chk("restart_pending", move_valid, 0);
      run_to(88);  chk("down_valid", move_valid, 1);
      chk("down_dir", move_dir, 2'b01);
      run_to(89);  chk("down_count", move_count, 3);
      dir = 3'd0;
      run_to(100); chk("down_release_idle", busy, 0);

      // Left held: one move at 112, handshake 113.
      dir = 3'd3;
      run_to(112); chk("left_valid", move_valid, 1);
      chk("left_dir", move_dir, 2'b10);
      run_to(113); chk("left_count", move_count, 4);
`ifdef MOVE_REPEAT_EN
      run_to(131); chk("rep_early", move_valid, 0);
      run_to(132); chk("rep1_valid", move_valid, 1);
      chk("rep1_dir", move_dir, 2'b10);
      run_to(151); chk("rep2_early", move_valid, 0);
      run_to(152); chk("rep2_valid", move_valid, 1);
      run_to(153); chk("rep2_count", move_count, 6);
      enable = 1'b0;
      while (cyc < 253) begin
         step();
         chk("rep_suppressed", move_valid, 0);
      end
      chk("rep_off_count", move_count, 6);
      enable = 1'b1; dir = 3'd0;
      t = 264; exp_cnt = 6;
`else
      while (cyc < 513) begin
         step();
         chk("held_no_repeat", move_valid, 0);
      end
      chk("held_count", move_count, 4);
      chk("held_busy", busy, 1);
      dir = 3'd0;
      t = 524; exp_cnt = 4;
`endif
      run_to(t);      chk("centre_idle", busy, 0);
      dir = 3'd3;
      run_to(t + 11); chk("second_pending", move_valid, 0);
      run_to(t + 12); chk("second_valid", move_valid, 1);
      chk("second_dir", move_dir, 2'b10);
      run_to(t + 13); chk("second_count", move_count, exp_cnt + 1);
      dir = 3'd0;
      run_to(t + 24); chk("second_release", busy, 0);

      // Reset while a move is pending.
      dir = 3'd1; move_ready = 1'b0;
      run_to(t + 36); chk("pend_valid", move_valid, 1);
      rst = 1'b1;
      step();
      chk("midrst_valid", move_valid, 0);
      chk("midrst_count", move_count, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0; cyc = 0; dir = 3'd7; move_ready = 1'b1;
      while (cyc < 40) begin
         step();
         chk("dir7_valid", move_valid, 0);
         chk("dir7_busy", busy, 0);
      end
      dir = 3'd1; enable = 1'b0;
      while (cyc < 60) begin
         step();
         chk("disabled_busy", busy, 0);
      end

      // Count wrap: 256 presses from zero.
      enable = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         dir = 3'd2;
         wait_sig(0, 64, "wrap_valid_timeout");
         dir = 3'd0;
         step();
         wait_sig(1, 64, "wrap_idle_timeout");
         if (i == 255) chk("count_255", move_count, 255);
      end
      chk("count_wrap", move_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
